// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew data-hazard and MDU-busy stall unit beside the D-stage decoder; optional HAZARD_STATS_EN stall counter.
// Latency: stall/stall_src are combinational from scoreboard state and current D inputs; state updates each clock.
// Backpressure: stall freezes F/D, and a stalled instruction is never recorded so it can be re-presented.
module hazard_scoreboard #(
    parameter int NREG       = 32,
    parameter int REG_AW     = 5,
    parameter int NSRC       = 2,
    parameter int TNEW_W     = 2,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NSRC-1:0]          src_valid,
    input  logic [NSRC*REG_AW-1:0]   src_reg,
    input  logic [NSRC*TNEW_W-1:0]   src_tuse,
    input  logic                     issue_valid,
    input  logic [REG_AW-1:0]        issue_dst,
    input  logic [TNEW_W-1:0]        issue_tnew,
    input  logic                     md_use,
    input  logic                     md_start,
    input  logic                     md_div,
    output logic                     stall,
    output logic [NSRC-1:0]          stall_src,
    output logic                     md_busy,
    output logic [31:0]              stall_cnt
);

    localparam int MD_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    logic [TNEW_W-1:0] cnt_q [NREG];
    logic [MD_W-1:0]   md_cnt;
    logic              md_stall;
    logic              record;

    assign record = issue_valid && !stall && (issue_dst != '0);

    // Entry 0 is only ever written by reset, so it stays a constant zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (record && (issue_dst == REG_AW'(r))) begin
                    cnt_q[r] <= issue_tnew;
                end else if (cnt_q[r] != '0) begin
                    cnt_q[r] <= cnt_q[r] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_src = '0;
        for (int i = 0; i < NSRC; i++) begin
            stall_src[i] = src_valid[i]
                        && (src_reg[i*REG_AW +: REG_AW] != '0)
                        && (cnt_q[src_reg[i*REG_AW +: REG_AW]] > src_tuse[i*TNEW_W +: TNEW_W]);
        end
    end

    // A start while busy cannot happen in a correct pipeline; it is simply ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt <= '0;
        end else if (md_start && (md_cnt == '0)) begin
            md_cnt <= md_div ? MD_W'(DIV_CYCLES) : MD_W'(MUL_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign md_busy  = (md_cnt != '0);
    assign md_stall = md_use && (md_busy || md_start);
    assign stall    = (|stall_src) || md_stall;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic, checked
// against a model that tracks the absolute cycle at which each result becomes forwardable.
module tb_hazard_scoreboard;
    localparam int NREG = 32, REG_AW = 5, NSRC = 2, TNEW_W = 2, MULC = 5, DIVC = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset_n;
    logic [NSRC-1:0]        src_valid;
    logic [NSRC*REG_AW-1:0] src_reg;
    logic [NSRC*TNEW_W-1:0] src_tuse;
    logic                   issue_valid;
    logic [REG_AW-1:0]      issue_dst;
    logic [TNEW_W-1:0]      issue_tnew;
    logic                   md_use, md_start, md_div;
    logic                   stall;
    logic [NSRC-1:0]        stall_src;
    logic                   md_busy;
    logic [31:0]            stall_cnt;

    hazard_scoreboard #(
        .NREG(NREG), .REG_AW(REG_AW), .NSRC(NSRC), .TNEW_W(TNEW_W),
        .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .src_valid(src_valid), .src_reg(src_reg), .src_tuse(src_tuse),
        .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_tnew(issue_tnew),
        .md_use(md_use), .md_start(md_start), .md_div(md_div),
        .stall(stall), .stall_src(stall_src), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic        stall;
        logic [1:0]  src;
        logic        busy;
        logic [31:0] scnt;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: absolute cycle numbers rather than countdowns.
    int now = 0;
    int ready_at [NREG];
    int md_free  = 0;
    int model_scnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            check("stall",     {31'd0, stall}, {31'd0, mon_e.stall});
            check("stall_src", {30'd0, stall_src}, {30'd0, mon_e.src});
            check("md_busy",   {31'd0, md_busy}, {31'd0, mon_e.busy});
            check("stall_cnt", stall_cnt, mon_e.scnt);
        end
    end

    function automatic int remaining(input int r);
        int d;
        d = ready_at[r] - now;
        return (d > 0) ? d : 0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   r, tu;
        for (int i = 0; i < NSRC; i++) begin
            r  = int'(src_reg[i*REG_AW +: REG_AW]);
            tu = int'(src_tuse[i*TNEW_W +: TNEW_W]);
            e.src[i] = src_valid[i] && (r != 0) && (remaining(r) > tu);
        end
        e.busy  = (now < md_free);
        e.stall = (|e.src) || (md_use && (e.busy || md_start));
`ifdef HAZARD_STATS_EN
        e.scnt  = 32'(model_scnt);
`else
        e.scnt  = 32'd0;
`endif
        return e;
    endfunction

    task automatic set_inputs(input logic v0, input int r0, input int t0,
                              input logic v1, input int r1, input int t1,
                              input logic iv, input int dst, input int tnew,
                              input logic mu, input logic ms, input logic md);
        src_valid   = {v1, v0};
        src_reg     = {5'(r1), 5'(r0)};
        src_tuse    = {2'(t1), 2'(t0)};
        issue_valid = iv;
        issue_dst   = 5'(dst);
        issue_tnew  = 2'(tnew);
        md_use      = mu;
        md_start    = ms;
        md_div      = md;
    endtask

    task automatic drive(input logic v0, input int r0, input int t0,
                         input logic v1, input int r1, input int t1,
                         input logic iv, input int dst, input int tnew,
                         input logic mu, input logic ms, input logic md);
        exp_t e;
        set_inputs(v0, r0, t0, v1, r1, t1, iv, dst, tnew, mu, ms, md);
        e = model_out();
        expq.push_back(e);
        @(posedge clk);
        if (iv && !e.stall && dst != 0) ready_at[dst] = now + 1 + tnew;
        if (ms && !(now < md_free)) md_free = now + 1 + (md ? DIVC : MULC);
        if (e.stall) model_scnt++;
        now++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One cycle with reset asserted mid-cycle while a hazard is being presented.
    task automatic reset_cycle(input logic mu, input int r0);
        set_inputs(1, r0, 0, 0, 0, 0, 0, 0, 0, mu, 0, 0);
        reset_n = 1'b0;
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
        md_free    = 0;
        model_scnt = 0;
        expq.push_back(model_out());
        @(posedge clk);
        now++;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
        @(posedge clk);
        #1;
        reset_cycle(0, 0);

        // lw $8 then beq on $8 (tuse 0): two stall cycles
        drive(0, 0, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0);
        repeat (3) drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // lw $8 then addu on $8 (tuse 1): one stall cycle
        drive(0, 0, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0);
        repeat (2) drive(1, 8, 1, 0, 0, 0, 1, 10, 1, 0, 0, 0);
        idle(3);
        // ori $9 then sw using $9 twice: fully forwardable
        drive(0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
        drive(1, 9, 1, 1, 9, 2, 0, 0, 0, 0, 0, 0);
        // writes to $0 are never tracked
        drive(0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // re-record $8 while its entry is counting down
        drive(0, 0, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0);
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // div in E with mflo in D, then mflo held
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        repeat (12) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // mult start without a dependent D instruction
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (7) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // reset while $8 pending and MDU busy
        drive(0, 0, 0, 0, 0, 0, 1, 8, 2, 0, 1, 1);
        drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        reset_cycle(1, 8);
        drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 79) == 0) begin
                reset_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            end else begin
                drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                      1'($urandom_range(0, 1)));
            end
        end

        idle(2);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
